cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 21 ++
 rtl/cdb_fifo.sv | 53 +++++
 rtl/cdb_arbiter.sv | 107 ++++++++++
 tb/tb_cdb_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared widths, producer indices and helpers for the CDB arbiter
`ifndef CDB_ARBITER_DEFINES
`define CDB_ARBITER_DEFINES
`define tagWidth 6
`define dataWidth 32
`endif

package cdb_arbiter_pkg;
    localparam int TAG_W   = `tagWidth;
    localparam int DATA_W  = `dataWidth;
    localparam int SRC_W   = 2;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSB = 1;
    localparam int SRC_BR  = 2;

    // Round-robin successor of a producer index, wrapping at nsrc.
    function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] idx, input int nsrc);
        return (int'(idx) == nsrc - 1) ? '0 : idx + 1'b1;
    endfunction
endpackage

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - per-producer holding FIFO feeding the CDB arbiter
module cdb_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] adv(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy tracking; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= adv(wr_ptr);
            if (do_pop)  rd_ptr <= adv(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; stale contents are harmless because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing one CDB between result producers
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NSRC  = 3,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NSRC-1:0]          req_valid,
    input  logic [NSRC*TAG_W-1:0]    req_tag,
    input  logic [NSRC*DATA_W-1:0]   req_data,
    output logic [NSRC-1:0]          req_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [1:0]               cdb_src
);
    localparam int EW = TAG_W + DATA_W;

    logic [NSRC-1:0]  empty;
    logic [NSRC-1:0]  full;
    logic [NSRC-1:0]  push;
    logic [NSRC-1:0]  pop;
    logic [EW-1:0]    head [NSRC];

    logic [SRC_W-1:0] rr_ptr;
    logic             hi_valid, lo_valid, grant_valid;
    logic [SRC_W-1:0] hi_idx, lo_idx, grant_idx;
    logic [EW-1:0]    hi_head, lo_head, grant_head;

    // Ready depends only on FIFO fullness, never on the producer's valid.
    assign req_ready = ~full;
    assign push      = req_valid & ~full;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        cdb_fifo #(
            .WIDTH (EW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[i]),
            .din   ({req_tag[i*TAG_W +: TAG_W], req_data[i*DATA_W +: DATA_W]}),
            .pop   (pop[i]),
            .dout  (head[i]),
            .empty (empty[i]),
            .full  (full[i])
        );
        assign pop[i] = grant_valid && (grant_idx == SRC_W'(i));
    end

    // Rotating priority: first non-empty at or above rr_ptr, else first non-empty from 0.
    always_comb begin
        hi_valid = 1'b0;
        hi_idx   = '0;
        hi_head  = '0;
        lo_valid = 1'b0;
        lo_idx   = '0;
        lo_head  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (!empty[i] && !lo_valid) begin
                lo_valid = 1'b1;
                lo_idx   = SRC_W'(i);
                lo_head  = head[i];
            end
            if (!empty[i] && !hi_valid && (i >= int'(rr_ptr))) begin
                hi_valid = 1'b1;
                hi_idx   = SRC_W'(i);
                hi_head  = head[i];
            end
        end
        grant_valid = hi_valid | lo_valid;
        grant_idx   = hi_valid ? hi_idx  : lo_idx;
        grant_head  = hi_valid ? hi_head : lo_head;
    end

    // Round-robin pointer advances past the winner; held on idle and flush cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= SRC_W'(SRC_ALU);
        end else if (!flush && grant_valid) begin
            rr_ptr <= rr_next(grant_idx, NSRC);
        end
    end

    // Broadcast register; payload fields hold their last value while idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= grant_valid;
            if (grant_valid) begin
                cdb_tag  <= grant_head[EW-1 -: TAG_W];
                cdb_data <= grant_head[DATA_W-1:0];
                cdb_src  <= grant_idx;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NSRC  = 3;
    localparam int DEPTH = 2;
    localparam int EW    = TAG_W + DATA_W;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic [NSRC-1:0]        req_valid;
    logic [NSRC*TAG_W-1:0]  req_tag;
    logic [NSRC*DATA_W-1:0] req_data;
    logic [NSRC-1:0]        req_ready;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [DATA_W-1:0]      cdb_data;
    logic [1:0]             cdb_src;

    cdb_arbiter #(.NSRC(NSRC), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    always #5 clk = ~clk;

    int nc = 0;
    int nf = 0;

    // Reference model: one queue per producer, a rotating start index, expected CDB.
    logic [EW-1:0]     mq [NSRC][$];
    int                m_rr;
    logic              m_valid;
    logic [TAG_W-1:0]  m_tag;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        m_src;
    bit                m_rdy [NSRC];
    int                m_g;
    logic [EW-1:0]     m_e;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NSRC; i++) mq[i].delete();
            m_rr = 0; m_valid = 0; m_tag = '0; m_data = '0; m_src = '0;
        end else begin
            for (int i = 0; i < NSRC; i++) m_rdy[i] = (mq[i].size() < DEPTH);
            m_g = -1;
            for (int k = 0; k < NSRC; k++)
                if (m_g < 0 && mq[(m_rr + k) % NSRC].size() > 0) m_g = (m_rr + k) % NSRC;
            if (flush) begin
                for (int i = 0; i < NSRC; i++) mq[i].delete();
                m_valid = 0;
            end else begin
                if (m_g >= 0) begin
                    m_e     = mq[m_g].pop_front();
                    m_valid = 1;
                    m_tag   = m_e[EW-1 -: TAG_W];
                    m_data  = m_e[DATA_W-1:0];
                    m_src   = 2'(m_g);
                    m_rr    = (m_g + 1) % NSRC;
                end else begin
                    m_valid = 0;
                end
                for (int i = 0; i < NSRC; i++)
                    if (req_valid[i] && m_rdy[i])
                        mq[i].push_back({req_tag[i*TAG_W +: TAG_W], req_data[i*DATA_W +: DATA_W]});
            end
        end
    end

    typedef struct { int src; int tag; } bc_t;
    bc_t log_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nc++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge, compare DUT to the model, record broadcasts.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NSRC; i++)
            chk($sformatf("req_ready[%0d]", i), 64'(req_ready[i]), 64'(mq[i].size() < DEPTH));
        chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        chk("cdb_tag",   64'(cdb_tag),   64'(m_tag));
        chk("cdb_data",  64'(cdb_data),  64'(m_data));
        chk("cdb_src",   64'(cdb_src),   64'(m_src));
        if (cdb_valid) log_q.push_back('{int'(cdb_src), int'(cdb_tag)});
    endtask

    task automatic set_src(input int i, input int tag, input logic [DATA_W-1:0] data);
        req_tag[i*TAG_W +: TAG_W]    = TAG_W'(tag);
        req_data[i*DATA_W +: DATA_W] = data;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    logic [NSRC-1:0] e2_ready;

    // All producers keep valid high, each advancing its tag once accepted.
    task automatic load(input int ncyc);
        int cnt [NSRC];
        logic [NSRC-1:0] rd;
        for (int i = 0; i < NSRC; i++) cnt[i] = 0;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < NSRC; i++)
                set_src(i, i * 20 + 1 + cnt[i], 32'hA000_0000 + 32'(i) * 32'h0100_0000 + 32'(cnt[i]));
            req_valid = '1;
            rd = req_ready;
            tick();
            for (int i = 0; i < NSRC; i++) if (rd[i]) cnt[i]++;
            if (c == 1) e2_ready = req_ready;
        end
    endtask

    int   idx;
    int   rot_bad;
    int   per_src [NSRC];
    logic rd1;

    initial begin
        rst = 1'b0; flush = 1'b0; req_valid = '0; req_tag = '0; req_data = '0;
        tick();
        tick();
        rst = 1'b1;
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_tag",   64'(cdb_tag),   64'd0);
        chk("rst_data",  64'(cdb_data),  64'd0);
        chk("rst_src",   64'(cdb_src),   64'd0);
        chk("rst_ready", 64'(req_ready), 64'h7);

        // Single ALU result: no bypass, appears one edge later, then idle.
        set_src(SRC_ALU, 5, 32'h0000_00AA);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        chk("single_no_bypass", 64'(cdb_valid), 64'd0);
        tick();
        chk("single_valid", 64'(cdb_valid), 64'd1);
        chk("single_tag",   64'(cdb_tag),   64'd5);
        chk("single_data",  64'(cdb_data),  64'hAA);
        chk("single_src",   64'(cdb_src),   64'd0);
        tick();
        chk("single_idle", 64'(cdb_valid), 64'd0);

        // Three simultaneous pushes from rr_ptr=0 broadcast in index order.
        reset_pulse();
        set_src(SRC_ALU, 1, 32'h11);
        set_src(SRC_LSB, 2, 32'h22);
        set_src(SRC_BR,  3, 32'h33);
        req_valid = 3'b111;
        tick();
        req_valid = '0;
        log_q.delete();
        for (int k = 0; k < 4; k++) tick();
        chk("three_count", 64'(log_q.size()), 64'd3);
        for (int k = 0; k < 3 && k < log_q.size(); k++) begin
            chk($sformatf("three_src%0d", k), 64'(log_q[k].src), 64'(k));
            chk($sformatf("three_tag%0d", k), 64'(log_q[k].tag), 64'(k + 1));
        end

        // LSBuffer streams three tags, holding each until accepted.
        idx = 0;
        log_q.delete();
        for (int c = 0; c < 10; c++) begin
            if (idx < 3) begin
                req_valid = 3'b010;
                set_src(SRC_LSB, 10 + idx, 32'hB000_0000 + 32'(idx));
            end else begin
                req_valid = '0;
            end
            rd1 = req_ready[SRC_LSB];
            tick();
            if (idx < 3 && rd1) idx++;
        end
        req_valid = '0;
        chk("lsb_accepted", 64'(idx), 64'd3);
        chk("lsb_count", 64'(log_q.size()), 64'd3);
        for (int k = 0; k < 3 && k < log_q.size(); k++) begin
            chk($sformatf("lsb_src%0d", k), 64'(log_q[k].src), 64'(SRC_LSB));
            chk($sformatf("lsb_tag%0d", k), 64'(log_q[k].tag), 64'(10 + k));
        end

        // Full load for 30 cycles: strict rotation, ten grants each, no bubbles.
        reset_pulse();
        log_q.delete();
        load(30);
        req_valid = '0;
        tick();
        chk("load_ready_e2", 64'(e2_ready), 64'h1);
        chk("load_count", 64'(log_q.size()), 64'd30);
        rot_bad = 0;
        for (int i = 0; i < NSRC; i++) per_src[i] = 0;
        for (int k = 0; k < log_q.size(); k++) begin
            if (log_q[k].src != k % 3) rot_bad++;
            if (log_q[k].src >= 0 && log_q[k].src < NSRC) per_src[log_q[k].src]++;
        end
        chk("load_rotation_errors", 64'(rot_bad), 64'd0);
        for (int i = 0; i < NSRC; i++) chk($sformatf("load_grants%0d", i), 64'(per_src[i]), 64'd10);

        // Flush with entries held and a live broadcast; flush-cycle pushes dropped.
        chk("flush_pre_valid", 64'(cdb_valid), 64'd1);
        flush = 1'b1;
        req_valid = 3'b111;
        set_src(SRC_ALU, 50, 32'h50);
        set_src(SRC_LSB, 51, 32'h51);
        set_src(SRC_BR,  52, 32'h52);
        tick();
        flush = 1'b0;
        req_valid = '0;
        chk("flush_valid", 64'(cdb_valid), 64'd0);
        chk("flush_ready", 64'(req_ready), 64'h7);
        log_q.delete();
        for (int k = 0; k < 4; k++) tick();
        chk("flush_no_bcast", 64'(log_q.size()), 64'd0);

        // Reset (with flush also high) mid-stream, then a 1-cycle-latency restart.
        load(6);
        rst = 1'b0;
        flush = 1'b1;
        tick();
        rst = 1'b1;
        flush = 1'b0;
        req_valid = '0;
        chk("mrst_valid", 64'(cdb_valid), 64'd0);
        chk("mrst_tag",   64'(cdb_tag),   64'd0);
        chk("mrst_data",  64'(cdb_data),  64'd0);
        chk("mrst_src",   64'(cdb_src),   64'd0);
        chk("mrst_ready", 64'(req_ready), 64'h7);
        set_src(SRC_ALU, 33, 32'h3300);
        set_src(SRC_LSB, 34, 32'h3400);
        set_src(SRC_BR,  35, 32'h3500);
        req_valid = 3'b111;
        tick();
        req_valid = '0;
        chk("post_rst_no_bypass", 64'(cdb_valid), 64'd0);
        tick();
        chk("post_rst_valid", 64'(cdb_valid), 64'd1);
        chk("post_rst_src",   64'(cdb_src),   64'd0);
        chk("post_rst_tag",   64'(cdb_tag),   64'd33);
        chk("post_rst_data",  64'(cdb_data),  64'h3300);
        for (int k = 0; k < 3; k++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end
endmodule
